ysyx_22050854_pc_gen: RTL and testbench

YSYX_22050854_PC_GEN -- requirements
Module: ysyx_22050854_pc_gen

---
 rtl/ysyx_22050854_pc_gen_if.sv | 36 +++
 rtl/ysyx_22050854_pc_gen.sv | 152 +++++++++++++++
 tb/tb_ysyx_22050854_pc_gen.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22050854_pc_gen_if.sv
// Fetch/resolve bus between the PC generator and the pipeline.
// master = PC generator, slave = fetch consumer / execute stage.
interface ysyx_22050854_pc_gen_if #(
  parameter int XLEN = 64,
  parameter int PC_W = 32
);
  logic            fetch_valid;
  logic            fetch_ready;
  logic [PC_W-1:0] fetch_pc;
  logic            fetch_pred_taken;
  logic [PC_W-1:0] fetch_pred_target;

  logic            res_valid;
  logic [1:0]      res_kind;
  logic [2:0]      res_cond;
  logic [PC_W-1:0] res_pc;
  logic [PC_W-1:0] res_imm;
  logic [XLEN-1:0] res_src1;
  logic [XLEN-1:0] res_src2;
  logic            res_pred_taken;
  logic [PC_W-1:0] res_pred_target;

  modport master (
    output fetch_valid, fetch_pc, fetch_pred_taken, fetch_pred_target,
    input  fetch_ready,
    input  res_valid, res_kind, res_cond, res_pc, res_imm,
    input  res_src1, res_src2, res_pred_taken, res_pred_target
  );

  modport slave (
    input  fetch_valid, fetch_pc, fetch_pred_taken, fetch_pred_target,
    output fetch_ready,
    output res_valid, res_kind, res_cond, res_pc, res_imm,
    output res_src1, res_src2, res_pred_taken, res_pred_target
  );
endinterface

// File: rtl/ysyx_22050854_pc_gen.sv
// PC generator: sequential/predicted fetch, branch resolution with redirect,
// direct-mapped BTB with 2-bit counters, misprediction counter.
module ysyx_22050854_pc_gen #(
  parameter int              XLEN      = 64,
  parameter int              PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_VEC = PC_W'(32'h8000_0000),
  parameter int              BTB_DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            csr_redirect,
  input  logic [PC_W-1:0] csr_pc,
  output logic            flush,
  output logic [31:0]     mispredict_cnt,
  ysyx_22050854_pc_gen_if.master fb
);
  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = PC_W - 2 - IDX_W;

  typedef enum logic {S_RESET, S_RUN} state_e;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [PC_W-1:0]  target;
    logic [1:0]       ctr;
  } btb_entry_t;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  btb_entry_t      btb_q [BTB_DEPTH];

  // ---- fetch-side lookup (reads registered contents: pre-update view)
  logic [IDX_W-1:0] f_idx;
  btb_entry_t       f_ent;
  logic             f_hit, f_pred_taken, f_valid, fire;
  logic [PC_W-1:0]  f_pred_target;

  assign f_idx         = pc_q[2 +: IDX_W];
  assign f_ent         = btb_q[f_idx];
  assign f_hit         = f_ent.valid && (f_ent.tag == pc_q[PC_W-1:2+IDX_W]);
  assign f_pred_taken  = f_hit && f_ent.ctr[1];
  assign f_pred_target = f_pred_taken ? f_ent.target : pc_q + PC_W'(4);

  assign fb.fetch_pc          = pc_q;
  assign fb.fetch_pred_taken  = f_pred_taken;
  assign fb.fetch_pred_target = f_pred_target;
  assign fb.fetch_valid       = f_valid;

  // ---- resolution
  logic            res_ok, cond_true, act_taken, mispredict, is_jalr;
  logic [PC_W-1:0] jalr_sum, act_target, correct_pc;

  assign res_ok  = fb.res_valid && (fb.res_kind != 2'b11);
  assign is_jalr = (fb.res_kind == 2'b10);

  always_comb begin
    cond_true = 1'b0;
    case (fb.res_cond)
      3'b000:  cond_true = (fb.res_src1 == fb.res_src2);
      3'b001:  cond_true = (fb.res_src1 != fb.res_src2);
      3'b100:  cond_true = ($signed(fb.res_src1) <  $signed(fb.res_src2));
      3'b101:  cond_true = ($signed(fb.res_src1) >= $signed(fb.res_src2));
      3'b110:  cond_true = (fb.res_src1 <  fb.res_src2);
      3'b111:  cond_true = (fb.res_src1 >= fb.res_src2);
      default: cond_true = 1'b0;
    endcase
  end

  assign act_taken  = (fb.res_kind == 2'b00) ? cond_true : 1'b1;
  assign jalr_sum   = fb.res_src1[PC_W-1:0] + fb.res_imm;
  assign act_target = is_jalr ? {jalr_sum[PC_W-1:1], 1'b0} : fb.res_pc + fb.res_imm;
  assign correct_pc = act_taken ? act_target : fb.res_pc + PC_W'(4);
  assign mispredict = res_ok && ((act_taken != fb.res_pred_taken) ||
                                 (act_taken && (act_target != fb.res_pred_target)));
  assign flush      = csr_redirect || mispredict;

  // ---- FSM / next PC
  always_comb begin
    state_d = state_q;
    f_valid = 1'b0;
    case (state_q)
      S_RESET: begin
        if (!rst) state_d = S_RUN;
      end
      S_RUN: begin
        f_valid = !stall && !flush;
        if (rst) state_d = S_RESET;
      end
      default: state_d = S_RESET;
    endcase
  end

  assign fire = f_valid && fb.fetch_ready;

  // Redirects bypass stall; reset overrides everything.
  always_comb begin
    pc_d = pc_q;
    if (rst)               pc_d = RESET_VEC;
    else if (csr_redirect) pc_d = csr_pc;
    else if (mispredict)   pc_d = correct_pc;
    else if (fire)         pc_d = f_pred_target;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_RESET;
      pc_q           <= RESET_VEC;
      mispredict_cnt <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (mispredict) mispredict_cnt <= mispredict_cnt + 32'd1;
    end
  end

  // ---- BTB training
  logic [IDX_W-1:0] r_idx;
  btb_entry_t       r_ent, upd_ent;
  logic             r_hit, upd_en;

  assign r_idx = fb.res_pc[2 +: IDX_W];
  assign r_ent = btb_q[r_idx];
  assign r_hit = r_ent.valid && (r_ent.tag == fb.res_pc[PC_W-1:2+IDX_W]);

  always_comb begin
    upd_ent = r_ent;
    upd_en  = 1'b0;
    if (res_ok) begin
      if (act_taken) begin
        upd_en         = 1'b1;
        upd_ent.valid  = 1'b1;
        upd_ent.tag    = fb.res_pc[PC_W-1:2+IDX_W];
        upd_ent.target = act_target;
        if (!r_hit)                 upd_ent.ctr = 2'd2;
        else if (r_ent.ctr != 2'd3) upd_ent.ctr = r_ent.ctr + 2'd1;
      end else if (r_hit && (r_ent.ctr != 2'd0)) begin
        upd_en      = 1'b1;
        upd_ent.ctr = r_ent.ctr - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BTB_DEPTH; i++) btb_q[i] <= '0;
    end else if (upd_en) begin
      btb_q[r_idx] <= upd_ent;
    end
  end
endmodule

// File: tb/tb_ysyx_22050854_pc_gen.sv
// Bench for ysyx_22050854_pc_gen: directed scenarios plus random traffic,
// checked every cycle against a behavioural BTB/PC model.
module tb_ysyx_22050854_pc_gen;
  localparam int          XLEN = 64;
  localparam int          PC_W = 32;
  localparam logic [31:0] RV   = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst, stall, csr_redirect, flush;
  logic [31:0] csr_pc, mispredict_cnt;

  ysyx_22050854_pc_gen_if #(.XLEN(XLEN), .PC_W(PC_W)) bus ();

  ysyx_22050854_pc_gen #(.XLEN(XLEN), .PC_W(PC_W), .RESET_VEC(RV), .BTB_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .stall(stall), .csr_redirect(csr_redirect), .csr_pc(csr_pc),
    .flush(flush), .mispredict_cnt(mispredict_cnt), .fb(bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---- behavioural model: 8-entry direct-mapped table indexed by word address
  bit          m_run;
  logic [31:0] m_pc, m_cnt;
  bit          m_v [8];
  logic [31:0] m_tag [8], m_tgt [8];
  int          m_ctr [8];

  task automatic m_reset();
    m_run = 0; m_pc = RV; m_cnt = 0;
    for (int i = 0; i < 8; i++) begin m_v[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 0; end
  endtask

  function automatic bit m_hit(input logic [31:0] pc);
    int i = int'((pc >> 2) % 8);
    return m_v[i] && (m_tag[i] == (pc >> 5));
  endfunction

  task automatic m_look(input logic [31:0] pc, output bit pt, output logic [31:0] tgt);
    int i = int'((pc >> 2) % 8);
    pt  = m_hit(pc) && (m_ctr[i] >= 2);
    tgt = pt ? m_tgt[i] : pc + 32'd4;
  endtask

  // sampled DUT outputs of the last step
  logic        s_fv, s_pt, s_flush;
  logic [31:0] s_pc, s_ptgt, s_cnt;

  task automatic step();
    bit          pt_e, tk, rv, mis, fl_e, fv_e, hit;
    logic [31:0] ptgt_e, tgt;
    logic [63:0] a, b;
    int          ri;
    @(negedge clk);
    s_fv = bus.fetch_valid; s_pc = bus.fetch_pc; s_pt = bus.fetch_pred_taken;
    s_ptgt = bus.fetch_pred_target; s_flush = flush; s_cnt = mispredict_cnt;
    m_look(m_pc, pt_e, ptgt_e);
    a = bus.res_src1; b = bus.res_src2;
    rv = bus.res_valid && (bus.res_kind != 2'b11);
    case (bus.res_cond)
      3'd0: tk = (a == b);
      3'd1: tk = (a != b);
      3'd4: tk = (longint'(a) <  longint'(b));
      3'd5: tk = (longint'(a) >= longint'(b));
      3'd6: tk = (a <  b);
      3'd7: tk = (a >= b);
      default: tk = 0;
    endcase
    if (bus.res_kind != 2'b00) tk = 1;
    tgt  = (bus.res_kind == 2'b10) ? ((a[31:0] + bus.res_imm) & ~32'd1) : bus.res_pc + bus.res_imm;
    mis  = rv && ((tk != bus.res_pred_taken) || (tk && (tgt != bus.res_pred_target)));
    fl_e = csr_redirect || mis;
    fv_e = m_run && !stall && !fl_e;
    check("fetch_valid", s_fv, fv_e);
    check("fetch_pc", s_pc, m_pc);
    check("pred_taken", s_pt, pt_e);
    check("pred_target", s_ptgt, ptgt_e);
    check("flush", s_flush, fl_e);
    check("mispredict_cnt", s_cnt, m_cnt);
    @(posedge clk);
    if (rst) m_reset();
    else begin
      m_run = 1;
      if (csr_redirect)                m_pc = csr_pc;
      else if (mis)                    m_pc = tk ? tgt : bus.res_pc + 32'd4;
      else if (fv_e && bus.fetch_ready) m_pc = ptgt_e;
      if (mis) m_cnt = m_cnt + 1;
      if (rv) begin
        ri  = int'((bus.res_pc >> 2) % 8);
        hit = m_hit(bus.res_pc);
        if (tk) begin
          m_ctr[ri] = hit ? ((m_ctr[ri] == 3) ? 3 : m_ctr[ri] + 1) : 2;
          m_v[ri] = 1; m_tag[ri] = bus.res_pc >> 5; m_tgt[ri] = tgt;
        end else if (hit && m_ctr[ri] > 0) m_ctr[ri] = m_ctr[ri] - 1;
      end
    end
    #1;
  endtask

  task automatic clr_res();
    bus.res_valid = 0; bus.res_kind = 0; bus.res_cond = 0; bus.res_pc = 0; bus.res_imm = 0;
    bus.res_src1 = 0; bus.res_src2 = 0; bus.res_pred_taken = 0; bus.res_pred_target = 0;
  endtask

  task automatic res_set(input logic [1:0] kind, input logic [2:0] cond, input logic [31:0] pc,
                         input logic [31:0] imm, input logic [63:0] s1, input logic [63:0] s2,
                         input bit pt, input logic [31:0] ptgt);
    bus.res_valid = 1; bus.res_kind = kind; bus.res_cond = cond; bus.res_pc = pc; bus.res_imm = imm;
    bus.res_src1 = s1; bus.res_src2 = s2; bus.res_pred_taken = pt; bus.res_pred_target = ptgt;
  endtask

  task automatic redirect(input logic [31:0] pc);
    csr_redirect = 1; csr_pc = pc; step(); csr_redirect = 0;
  endtask

  task automatic rand_inputs();
    logic [63:0] s1, s2;
    logic [31:0] pc, imm, ptgt;
    bit          pt;
    rst = ($urandom_range(0, 255) == 0);
    stall = ($urandom_range(0, 4) == 0);
    bus.fetch_ready = ($urandom_range(0, 4) != 0);
    csr_redirect = ($urandom_range(0, 19) == 0);
    csr_pc = RV + 32'($urandom_range(0, 47)) * 4;
    pc  = RV + 32'($urandom_range(0, 47)) * 4;
    imm = (32'($urandom_range(0, 64)) - 32'd32) * 4 + (($urandom_range(0, 3) == 0) ? 32'd1 : 32'd0);
    s1  = {$urandom, $urandom};
    case ($urandom_range(0, 3))
      0: s2 = s1;
      1: s2 = {$urandom, $urandom};
      2: s2 = s1 ^ 64'h8000_0000_0000_0000;
      default: s2 = s1 + 64'd1;
    endcase
    if ($urandom_range(0, 1) == 0) m_look(pc, pt, ptgt);
    else begin pt = $urandom_range(0, 1) == 1; ptgt = pc + (($urandom_range(0, 1) == 1) ? imm : 32'd4); end
    res_set(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), pc, imm, s1, s2, pt, ptgt);
    bus.res_valid = ($urandom_range(0, 2) == 0);
  endtask

  initial begin
    rst = 1; stall = 0; csr_redirect = 0; csr_pc = 0; bus.fetch_ready = 1; clr_res();
    m_reset();
    step(); step();
    check("rst_fetch_valid", s_fv, 0);
    check("rst_pc", s_pc, RV);
    check("rst_cnt", s_cnt, 0);
    rst = 0; step();
    // sequential fetch
    step(); check("seq_pc0", s_pc, 32'h8000_0000); check("seq_pt0", s_pt, 0);
    step(); check("seq_pc1", s_pc, 32'h8000_0004);
    stall = 1;
    repeat (3) begin
      step(); check("stall_fv", s_fv, 0); check("stall_pc", s_pc, 32'h8000_0008);
    end
    stall = 0;
    step(); step();
    // beq mispredict at 80000010 then train
    res_set(2'b00, 3'b000, 32'h8000_0010, 32'h20, 64'd5, 64'd5, 0, 32'h8000_0014);
    step(); check("bmis_flush", s_flush, 1);
    clr_res(); step(); check("bmis_pc", s_pc, 32'h8000_0030); check("bmis_cnt", s_cnt, 1);
    redirect(32'h8000_0010);
    step(); check("train_pt", s_pt, 1); check("train_tgt", s_ptgt, 32'h8000_0030);
    // counter decay 2->1->0
    res_set(2'b00, 3'b000, 32'h8000_0010, 32'h20, 64'd5, 64'd6, 1, 32'h8000_0030);
    step(); check("dec1_flush", s_flush, 1);
    res_set(2'b00, 3'b000, 32'h8000_0010, 32'h20, 64'd5, 64'd6, 0, 32'h8000_0014);
    step(); check("dec2_flush", s_flush, 0); check("dec2_cnt", s_cnt, 2);
    clr_res(); redirect(32'h8000_0010);
    step(); check("dec_pt", s_pt, 0); check("dec_tgt", s_ptgt, 32'h8000_0014);
    // taken from ctr 0 reaches only 1: still predicted not taken
    res_set(2'b00, 3'b000, 32'h8000_0010, 32'h20, 64'd7, 64'd7, 0, 32'h8000_0014);
    step();
    clr_res(); redirect(32'h8000_0010);
    step(); check("ctr1_pt", s_pt, 0);
    // jalr clears bit 0
    res_set(2'b10, 3'b000, 32'h8000_0040, 32'h0, 64'h8000_1003, 64'd0, 0, 32'h8000_0044);
    step(); check("jalr_flush", s_flush, 1);
    clr_res(); step(); check("jalr_pc", s_pc, 32'h8000_1002);
    // csr redirect beats mispredict, with stall
    stall = 1; csr_redirect = 1; csr_pc = 32'h8000_0100;
    res_set(2'b00, 3'b000, 32'h8000_0020, 32'h8, 64'd1, 64'd1, 0, 32'h8000_0024);
    step(); check("prio_flush", s_flush, 1);
    clr_res(); csr_redirect = 0;
    step(); check("prio_pc", s_pc, 32'h8000_0100); check("prio_cnt", s_cnt, 5);
    stall = 0;
    // random traffic
    repeat (3000) begin rand_inputs(); step(); end
    // mid-stream reset empties the BTB
    rst = 0; stall = 0; csr_redirect = 0; bus.fetch_ready = 1;
    res_set(2'b01, 3'b000, 32'h8000_0004, 32'h40, 64'd0, 64'd0, 0, 32'h8000_0008);
    step(); clr_res(); redirect(32'h8000_0004);
    step(); check("pre_rst_pt", s_pt, 1);
    rst = 1; csr_redirect = 1; csr_pc = 32'h8000_0200;
    res_set(2'b01, 3'b000, 32'h8000_0000, 32'h80, 64'd0, 64'd0, 0, 32'h8000_0004);
    step();
    rst = 0; csr_redirect = 0; clr_res();
    step(); check("rstmid_pc", s_pc, RV); check("rstmid_fv", s_fv, 0);
    for (int k = 0; k < 8; k++) begin
      step();
      check("post_rst_pc", s_pc, RV + 32'(k) * 4);
      check("post_rst_pt", s_pt, 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
